// File: rtl/burst_cache_fsm_pkg.sv
// Shared cache-controller types: request opcodes and the burst controller state set.
// Also provides the beat index width rule used by the controller and its beat counter.
package cache_types;

  typedef enum logic [1:0] {
    CACHE_OP_NONE,
    CACHE_OP_READ,
    CACHE_OP_WRITE
  } cache_op_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    FETCH,
    FILL_WAIT,
    WRITE_AROUND
  } burst_ctrl_state_t;

  // A single-beat line still needs a one-bit index.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/burst_cache_fsm_beat_counter.sv
// Beat index counter for DFP line bursts: wraps to zero after the last beat.
// Also exposes a last-beat flag.
module beat_counter #(
  parameter int BURST_BEATS = 4,
  parameter int BW          = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [BW-1:0] count,
  output logic          last
);

  logic [BW-1:0] count_reg;

  assign count = count_reg;
  assign last  = (count_reg == BW'(BURST_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= last ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/burst_cache_fsm.sv
// Burst cache controller: hit check, dirty-line writeback, line fill and optional write-around.
// Also keeps saturating hit/miss performance counters.
module burst_cache_fsm
  import cache_types::*;
#(
  parameter int WAYS        = 8,
  parameter int BURST_BEATS = 4,
  parameter int WRITE_ALLOC = 1,
  parameter int CNT_W       = 16,
  localparam int BW         = beat_width(BURST_BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cache_read_request,
  input  logic             cache_write_request,
  input  logic             cache_hit,
  input  logic [WAYS-1:0]  hit_way,
  input  logic [WAYS-1:0]  victim_way,
  input  logic             dirty,
  input  logic             dfp_resp,
  output logic             ufp_resp,
  output logic             dfp_read,
  output logic             dfp_write,
  output logic             dfp_write_around,
  output logic [BW-1:0]    beat_idx,
  output logic [WAYS-1:0]  tag_csb0,
  output logic [WAYS-1:0]  data_csb0,
  output logic [WAYS-1:0]  valid_csb0,
  output logic             write_from_mem,
  output logic             write_from_cpu,
  output logic             idle,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  burst_ctrl_state_t state_reg, state_next;
  logic [WAYS-1:0]   victim_reg;
  logic              refill_reg;
  logic [CNT_W-1:0]  hit_cnt_reg, miss_cnt_reg;
  logic [WAYS-1:0]   csb;
  logic              beat_inc, beat_clear, beat_last;

  beat_counter #(
    .BURST_BEATS (BURST_BEATS),
    .BW          (BW)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (beat_clear),
    .inc   (beat_inc),
    .count (beat_idx),
    .last  (beat_last)
  );

  assign tag_csb0   = csb;
  assign data_csb0  = csb;
  assign valid_csb0 = csb;
  assign idle       = (state_reg == IDLE);
  assign hit_cnt    = hit_cnt_reg;
  assign miss_cnt   = miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ufp_resp         = 1'b0;
    dfp_read         = 1'b0;
    dfp_write        = 1'b0;
    dfp_write_around = 1'b0;
    write_from_mem   = 1'b0;
    write_from_cpu   = 1'b0;
    csb              = '1;
    beat_inc         = 1'b0;
    beat_clear       = 1'b0;
    // Outputs stay quiet during reset even if the state register is mid-burst.
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          beat_clear = 1'b1;
          if (cache_read_request || cache_write_request) begin
            csb        = '0;
            state_next = CHECK;
          end
        end
        CHECK: begin
          if (cache_hit) begin
            ufp_resp       = 1'b1;
            write_from_cpu = cache_write_request;
            csb            = ~hit_way;
            state_next     = IDLE;
          end else if ((WRITE_ALLOC == 0) && cache_write_request) begin
            state_next = WRITE_AROUND;
          end else if (dirty) begin
            state_next = WRITEBACK;
          end else begin
            state_next = FETCH;
          end
        end
        WRITEBACK: begin
          dfp_write = 1'b1;
          csb       = ~victim_reg;
          if (dfp_resp) begin
            beat_inc = 1'b1;
            if (beat_last) state_next = FETCH;
          end
        end
        FETCH: begin
          dfp_read = 1'b1;
          if (dfp_resp) begin
            write_from_mem = 1'b1;
            csb            = ~victim_reg;
            beat_inc       = 1'b1;
            if (beat_last) state_next = FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          csb        = '0;
          state_next = CHECK;
        end
        WRITE_AROUND: begin
          dfp_write_around = 1'b1;
          if (dfp_resp) begin
            ufp_resp   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // refill_reg marks the re-CHECK after a fill so a request is counted as a miss only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_reg   <= '0;
      refill_reg   <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (state_reg == FILL_WAIT) begin
        refill_reg <= 1'b1;
      end else if (state_reg == IDLE) begin
        refill_reg <= 1'b0;
      end
      if (state_reg == CHECK) begin
        if (cache_hit) begin
          if (hit_cnt_reg != {CNT_W{1'b1}}) hit_cnt_reg <= hit_cnt_reg + 1'b1;
        end else begin
          victim_reg <= victim_way;
          if (!refill_reg && (miss_cnt_reg != {CNT_W{1'b1}})) begin
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_cache_fsm.sv
// Self-checking bench: two controller instances (write-allocate 4-beat/16-bit counters and
// write-around 1-beat/2-bit counters) driven by directed and random transactions.
module tb_burst_cache_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rd_req [2];
  logic       wr_req [2];
  logic       hit_in [2];
  logic       dirty_in [2];
  logic       resp_in [2];
  logic [7:0] hw_in [2];
  logic [7:0] vw_in [2];

  logic       ufp_o [2];
  logic       dr_o [2];
  logic       dw_o [2];
  logic       wa_o [2];
  logic       wfm_o [2];
  logic       wfc_o [2];
  logic       idle_o [2];
  logic [7:0] tcsb_o [2];
  logic [7:0] dcsb_o [2];
  logic [7:0] vcsb_o [2];
  logic [1:0] beat0;
  logic [0:0] beat1;
  logic [15:0] hit0, miss0;
  logic [1:0]  hit1, miss1;

  int n_cmp = 0;
  int n_bad = 0;
  int hits [2];
  int misses [2];
  int n_txn = 0;

  burst_cache_fsm #(.WAYS(8), .BURST_BEATS(4), .WRITE_ALLOC(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .cache_read_request(rd_req[0]), .cache_write_request(wr_req[0]),
    .cache_hit(hit_in[0]), .hit_way(hw_in[0]), .victim_way(vw_in[0]),
    .dirty(dirty_in[0]), .dfp_resp(resp_in[0]),
    .ufp_resp(ufp_o[0]), .dfp_read(dr_o[0]), .dfp_write(dw_o[0]),
    .dfp_write_around(wa_o[0]), .beat_idx(beat0),
    .tag_csb0(tcsb_o[0]), .data_csb0(dcsb_o[0]), .valid_csb0(vcsb_o[0]),
    .write_from_mem(wfm_o[0]), .write_from_cpu(wfc_o[0]), .idle(idle_o[0]),
    .hit_cnt(hit0), .miss_cnt(miss0)
  );

  burst_cache_fsm #(.WAYS(8), .BURST_BEATS(1), .WRITE_ALLOC(0), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .cache_read_request(rd_req[1]), .cache_write_request(wr_req[1]),
    .cache_hit(hit_in[1]), .hit_way(hw_in[1]), .victim_way(vw_in[1]),
    .dirty(dirty_in[1]), .dfp_resp(resp_in[1]),
    .ufp_resp(ufp_o[1]), .dfp_read(dr_o[1]), .dfp_write(dw_o[1]),
    .dfp_write_around(wa_o[1]), .beat_idx(beat1),
    .tag_csb0(tcsb_o[1]), .data_csb0(dcsb_o[1]), .valid_csb0(vcsb_o[1]),
    .write_from_mem(wfm_o[1]), .write_from_cpu(wfc_o[1]), .idle(idle_o[1]),
    .hit_cnt(hit1), .miss_cnt(miss1)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int beats_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // eidle / ebeat < 0 means "not checked this cycle".
  task automatic expect_cyc(input int d, input string tag, input bit eu, input bit edr,
                            input bit edw, input bit ewa, input bit ewfm, input bit ewfc,
                            input logic [7:0] ecsb, input int eidle, input int ebeat);
    int beat;
    beat = (d == 0) ? int'(beat0) : int'(beat1);
    chk({tag, ".ufp_resp"}, 32'(ufp_o[d]), 32'(eu));
    chk({tag, ".dfp_read"}, 32'(dr_o[d]), 32'(edr));
    chk({tag, ".dfp_write"}, 32'(dw_o[d]), 32'(edw));
    chk({tag, ".dfp_write_around"}, 32'(wa_o[d]), 32'(ewa));
    chk({tag, ".write_from_mem"}, 32'(wfm_o[d]), 32'(ewfm));
    chk({tag, ".write_from_cpu"}, 32'(wfc_o[d]), 32'(ewfc));
    chk({tag, ".tag_csb0"}, 32'(tcsb_o[d]), 32'(ecsb));
    chk({tag, ".data_csb0"}, 32'(dcsb_o[d]), 32'(ecsb));
    chk({tag, ".valid_csb0"}, 32'(vcsb_o[d]), 32'(ecsb));
    if (eidle >= 0) chk({tag, ".idle"}, 32'(idle_o[d]), 32'(eidle));
    if (ebeat >= 0) chk({tag, ".beat_idx"}, 32'(beat), 32'(ebeat));
  endtask

  task automatic check_counters(input int d);
    logic [31:0] h, m;
    h = (d == 0) ? 32'(hit0) : 32'(hit1);
    m = (d == 0) ? 32'(miss0) : 32'(miss1);
    chk("hit_cnt", h, 32'(sat(hits[d], cnt_max(d))));
    chk("miss_cnt", m, 32'(sat(misses[d], cnt_max(d))));
  endtask

  task automatic clear_inputs(input int d);
    rd_req[d] = 1'b0; wr_req[d] = 1'b0; hit_in[d] = 1'b0;
    dirty_in[d] = 1'b0; resp_in[d] = 1'b0;
  endtask

  task automatic finish_req(input int d);
    clear_inputs(d);
    #1;
    expect_cyc(d, "back_idle", 0, 0, 0, 0, 0, 0, 8'hFF, 1, 0);
    check_counters(d);
  endtask

  // One burst phase: optional idle gap cycles, then the accepted beat, per beat of the line.
  task automatic burst_phase(input int d, input bit is_fetch, input logic [7:0] vw,
                             input int gap);
    int g;
    for (int b = 0; b < beats_of(d); b++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
      for (int i = 0; i < g; i++) begin
        resp_in[d] = 1'b0;
        #1;
        expect_cyc(d, is_fetch ? "fetch_gap" : "wb_gap", 0, is_fetch, !is_fetch, 0, 0, 0,
                   is_fetch ? 8'hFF : ~vw, 0, b);
        tick();
      end
      resp_in[d] = 1'b1;
      #1;
      expect_cyc(d, is_fetch ? "fetch_beat" : "wb_beat", 0, is_fetch, !is_fetch, 0, is_fetch,
                 0, ~vw, 0, b);
      tick();
      resp_in[d] = 1'b0;
    end
  endtask

  task automatic run_txn(input int d, input bit wr, input bit hit, input bit drt,
                         input logic [7:0] hw, input logic [7:0] vw, input int gap);
    logic [7:0] vw_alt;
    int g;
    n_txn++;
    $display("txn %0d: inst=%0d %s hit=%0b dirty=%0b hit_way=%h victim=%h", n_txn, d,
             wr ? "write" : "read", hit, drt, hw, vw);
    rd_req[d] = !wr;
    wr_req[d] = wr;
    #1;
    expect_cyc(d, "idle_req", 0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
    tick();
    hit_in[d] = hit; hw_in[d] = hw; vw_in[d] = vw; dirty_in[d] = drt;
    #1;
    if (hit) begin
      expect_cyc(d, "check_hit", 1, 0, 0, 0, 0, wr, ~hw, 0, 0);
      hits[d]++;
      tick();
      finish_req(d);
      return;
    end
    expect_cyc(d, "check_miss", 0, 0, 0, 0, 0, 0, 8'hFF, 0, 0);
    misses[d]++;
    tick();
    // Disturb the CAM-side inputs: the controller must keep using the latched victim.
    vw_alt = {vw[6:0], vw[7]};
    vw_in[d] = vw_alt;
    hit_in[d] = 1'b0;
    dirty_in[d] = !drt;
    if (wr && d == 1) begin
      g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
      for (int i = 0; i < g; i++) begin
        #1;
        expect_cyc(d, "wa_wait", 0, 0, 0, 1, 0, 0, 8'hFF, 0, 0);
        tick();
      end
      resp_in[d] = 1'b1;
      #1;
      expect_cyc(d, "wa_resp", 1, 0, 0, 1, 0, 0, 8'hFF, 0, 0);
      tick();
      finish_req(d);
      return;
    end
    if (drt) burst_phase(d, 1'b0, vw, gap);
    burst_phase(d, 1'b1, vw, gap);
    #1;
    expect_cyc(d, "fill_wait", 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    tick();
    hit_in[d] = 1'b1;
    hw_in[d] = vw;
    #1;
    expect_cyc(d, "recheck_hit", 1, 0, 0, 0, 0, wr, ~vw, 0, 0);
    hits[d]++;
    tick();
    finish_req(d);
  endtask

  function automatic logic [7:0] rand_onehot();
    logic [7:0] one;
    one = 8'h01;
    return one << $urandom_range(0, 7);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      clear_inputs(d);
      hw_in[d] = '0; vw_in[d] = '0;
      hits[d] = 0; misses[d] = 0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) expect_cyc(d, "reset_cycle", 0, 0, 0, 0, 0, 0, 8'hFF, -1, -1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      expect_cyc(d, "after_reset", 0, 0, 0, 0, 0, 0, 8'hFF, 1, 0);
      check_counters(d);
    end
    tick();

    run_txn(0, 1'b0, 1'b1, 1'b0, 8'h04, 8'h01, 0);     // read hit on way 2
    run_txn(0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 0);     // dirty read miss
    run_txn(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 3);     // clean miss, 3-cycle beat gaps
    run_txn(0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 1);     // write-allocate dirty write miss
    run_txn(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h08, 2);     // write-around miss
    run_txn(1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h40, 1);     // single-beat dirty read miss
    for (int i = 0; i < 5; i++) run_txn(1, 1'b0, 1'b1, 1'b0, rand_onehot(), 8'h01, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rand_onehot(), rand_onehot(), -1);
    end

    // Reset in the middle of a line fill: the burst is abandoned immediately.
    n_txn++;
    $display("txn %0d: inst=0 read miss with reset during fetch beat 2", n_txn);
    rd_req[0] = 1'b1;
    tick();
    hit_in[0] = 1'b0; vw_in[0] = 8'h20; dirty_in[0] = 1'b0;
    tick();
    misses[0]++;
    for (int b = 0; b < 2; b++) begin
      resp_in[0] = 1'b1;
      #1;
      expect_cyc(0, "pre_reset_fetch", 0, 1, 0, 0, 1, 0, 8'hDF, 0, b);
      tick();
    end
    rst = 1'b1;
    #1;
    expect_cyc(0, "reset_mid_fetch", 0, 0, 0, 0, 0, 0, 8'hFF, -1, -1);
    tick();
    rst = 1'b0;
    clear_inputs(0);
    for (int d = 0; d < 2; d++) begin
      hits[d] = 0;
      misses[d] = 0;
    end
    #1;
    expect_cyc(0, "post_reset", 0, 0, 0, 0, 0, 0, 8'hFF, 1, 0);
    check_counters(0);
    check_counters(1);
    tick();
    run_txn(0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
